// File: rtl/waveform_plotter.sv
// Oscilloscope-style column plotter: decimates multi-channel samples, then per column
// erases x=col and draws a connected vertical segment per channel, one pixel per cycle.
module waveform_plotter #(
    parameter int                  SAMPLE_W = 24,
    parameter int                  NUM_CH   = 2,
    parameter int                  SCREEN_W = 160,
    parameter int                  SCREEN_H = 120,
    parameter int                  X_W      = 8,
    parameter int                  Y_W      = 7,
    parameter int                  DECIM    = 1000,
    parameter int                  SHIFT    = 17,
    parameter logic [3*NUM_CH-1:0] COLOURS  = 6'b100_010
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         continuous,
    input  logic                         arm,
    input  logic                         sample_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   sample_in,
    output logic                         plot,
    output logic [X_W-1:0]               x_out,
    output logic [Y_W-1:0]               y_out,
    output logic [2:0]                   colour,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);

    localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EXT_W  = SAMPLE_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_ERASE, S_DRAW, S_NEXT, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [X_W-1:0]              col_q, col_d;
    logic [DCNT_W-1:0]           dcnt_q, dcnt_d;
    logic [NUM_CH*SAMPLE_W-1:0]  samp_q, samp_d;
    logic [Y_W-1:0]              prev_y_q [NUM_CH];
    logic [Y_W-1:0]              prev_y_d [NUM_CH];
    logic [Y_W-1:0]              row_q, row_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic                        plot_q, plot_d;
    logic [X_W-1:0]              x_q, x_d;
    logic [Y_W-1:0]              y_q, y_d;
    logic [2:0]                  colour_q, colour_d;
    logic                        busy_q, busy_d;
    logic                        frame_done_q, frame_done_d;
    logic                        overrun_q, overrun_d;

    logic [Y_W-1:0]              new_y [NUM_CH];
    logic [Y_W-1:0]              tgt_y, first_start, nxt_start;
    logic [2:0]                  draw_colour;
    logic                        col_sample;

    // Arithmetic shift, flip so positive is up, then clamp into the visible rows.
    function automatic logic [Y_W-1:0] map_y(input logic [SAMPLE_W-1:0] raw);
        logic signed [SAMPLE_W-1:0] sh;
        logic signed [EXT_W-1:0]    d;
        sh = $signed(raw) >>> SHIFT;
        d  = EXT_W'(SCREEN_H / 2) - EXT_W'(sh);
        if (d[EXT_W-1])
            map_y = '0;
        else if (d > EXT_W'(SCREEN_H - 1))
            map_y = Y_W'(SCREEN_H - 1);
        else
            map_y = d[Y_W-1:0];
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            new_y[c] = map_y(samp_q[c*SAMPLE_W +: SAMPLE_W]);
    end

    // Column 0 has no predecessor, so each segment starts at its own end point.
    always_comb begin
        tgt_y       = new_y[0];
        draw_colour = COLOURS[2:0];
        nxt_start   = new_y[0];
        first_start = (col_q == '0) ? new_y[0] : prev_y_q[0];
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CH_W'(c)) begin
                tgt_y       = new_y[c];
                draw_colour = COLOURS[3*c +: 3];
            end
            if (c > 0 && ch_q == CH_W'(c - 1))
                nxt_start = (col_q == '0) ? new_y[c] : prev_y_q[c];
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        dcnt_d       = dcnt_q;
        samp_d       = samp_q;
        prev_y_d     = prev_y_q;
        row_d        = row_q;
        ch_d         = ch_q;
        plot_d       = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        col_sample   = 1'b0;

        if (enable && sample_valid) begin
            if (dcnt_q == DCNT_W'(DECIM - 1)) begin
                dcnt_d     = '0;
                col_sample = 1'b1;
            end else begin
                dcnt_d = dcnt_q + DCNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (col_sample) begin
                    samp_d  = sample_in;
                    row_d   = '0;
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                plot_d   = 1'b1;
                busy_d   = 1'b1;
                x_d      = col_q;
                y_d      = row_q;
                colour_d = 3'b000;
                if (row_q == Y_W'(SCREEN_H - 1)) begin
                    ch_d    = '0;
                    row_d   = first_start;
                    state_d = S_DRAW;
                end else begin
                    row_d = row_q + Y_W'(1);
                end
            end
            S_DRAW: begin
                plot_d   = 1'b1;
                busy_d   = 1'b1;
                x_d      = col_q;
                y_d      = row_q;
                colour_d = draw_colour;
                if (row_q == tgt_y) begin
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        state_d = S_NEXT;
                    end else begin
                        ch_d  = ch_q + CH_W'(1);
                        row_d = nxt_start;
                    end
                end else if (row_q < tgt_y) begin
                    row_d = row_q + Y_W'(1);
                end else begin
                    row_d = row_q - Y_W'(1);
                end
            end
            S_NEXT: begin
                prev_y_d = new_y;
                if (col_q == X_W'(SCREEN_W - 1)) begin
                    frame_done_d = 1'b1;
                    if (continuous) begin
                        col_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    col_d   = col_q + X_W'(1);
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (arm) begin
                    col_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (col_sample && (state_q == S_ERASE || state_q == S_DRAW || state_q == S_NEXT))
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            dcnt_q       <= '0;
            samp_q       <= '0;
            for (int c = 0; c < NUM_CH; c++)
                prev_y_q[c] <= Y_W'(SCREEN_H / 2);
            row_q        <= '0;
            ch_q         <= '0;
            plot_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= 3'b000;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            dcnt_q       <= dcnt_d;
            samp_q       <= samp_d;
            prev_y_q     <= prev_y_d;
            row_q        <= row_d;
            ch_q         <= ch_d;
            plot_q       <= plot_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign plot       = plot_q;
    assign x_out      = x_q;
    assign y_out      = y_q;
    assign colour     = colour_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_waveform_plotter.sv
// Bench for waveform_plotter: three configurations, expected pixels queued per column
// and popped by a negedge monitor as the plotter writes them.
module tb_waveform_plotter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vec  = 0;
    int miss = 0;

    // dut1: NUM_CH=1, DECIM=4; dut2: NUM_CH=2, DECIM=1; dut3: NUM_CH=1, DECIM=1, SCREEN_W=4
    logic r1, e1, cn1, a1, v1;
    logic [23:0] s1;
    logic p1, b1, f1, o1;
    logic [7:0] x1;
    logic [6:0] y1;
    logic [2:0] c1;

    logic r2, e2, cn2, a2, v2;
    logic [47:0] s2;
    logic p2, b2, f2, o2;
    logic [7:0] x2;
    logic [6:0] y2;
    logic [2:0] c2;

    logic r3, e3, cn3, a3, v3;
    logic [23:0] s3;
    logic p3, b3, f3, o3;
    logic [7:0] x3;
    logic [6:0] y3;
    logic [2:0] c3;

    waveform_plotter #(.NUM_CH(1), .DECIM(4), .COLOURS(3'b010)) dut1 (
        .clk(clk), .reset(r1), .enable(e1), .continuous(cn1), .arm(a1),
        .sample_valid(v1), .sample_in(s1), .plot(p1), .x_out(x1), .y_out(y1),
        .colour(c1), .busy(b1), .frame_done(f1), .overrun(o1));

    waveform_plotter #(.NUM_CH(2), .DECIM(1)) dut2 (
        .clk(clk), .reset(r2), .enable(e2), .continuous(cn2), .arm(a2),
        .sample_valid(v2), .sample_in(s2), .plot(p2), .x_out(x2), .y_out(y2),
        .colour(c2), .busy(b2), .frame_done(f2), .overrun(o2));

    waveform_plotter #(.NUM_CH(1), .DECIM(1), .SCREEN_W(4), .COLOURS(3'b001)) dut3 (
        .clk(clk), .reset(r3), .enable(e3), .continuous(cn3), .arm(a3),
        .sample_valid(v3), .sample_in(s3), .plot(p3), .x_out(x3), .y_out(y3),
        .colour(c3), .busy(b3), .frame_done(f3), .overrun(o3));

    logic [17:0] sb [3][$];
    int   fdc [3];
    logic lp [3];
    int   lx [3];
    int   cx [3];
    int   py [3];

    function automatic int width_of(int id);
        return (id == 2) ? 4 : 160;
    endfunction

    function automatic logic [2:0] colour_of(int id);
        return (id == 2) ? 3'b001 : 3'b010;
    endfunction

    function automatic logic busy_of(int id);
        return (id == 0) ? b1 : (id == 1) ? b2 : b3;
    endfunction

    task automatic stop_now(string tag);
        vec++;
        miss++;
        $display("FAIL %s timeout got=no_event expected=event", tag);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $fatal(1, "aborted");
    endtask

    task automatic push_seg(int id, int x, int a, int b, logic [2:0] k);
        int y;
        y = a;
        sb[id].push_back({8'(x), 7'(y), k});
        while (y != b) begin
            y += (b > y) ? 1 : -1;
            sb[id].push_back({8'(x), 7'(y), k});
        end
    endtask

    task automatic push_col(int id, int x, int nch, int ny0, int ny1, int py0, int py1,
                            logic [2:0] k0, logic [2:0] k1);
        for (int r = 0; r < 120; r++)
            sb[id].push_back({8'(x), 7'(r), 3'b000});
        push_seg(id, x, (x == 0) ? ny0 : py0, ny0, k0);
        if (nch == 2)
            push_seg(id, x, (x == 0) ? ny1 : py1, ny1, k1);
    endtask

    task automatic check_px(int id, logic [17:0] got);
        logic [17:0] e;
        vec++;
        assert (sb[id].size() != 0) else begin
            miss++;
            $error("FAIL px%0d_extra got=%h expected=none", id, got);
        end
        if (sb[id].size() != 0) begin
            e = sb[id].pop_front();
            vec++;
            assert (got === e) else begin
                miss++;
                $error("FAIL px%0d got=%h expected=%h", id, got, e);
            end
        end
    endtask

    task automatic mon(int id, logic p, logic b, logic [17:0] px, logic fd);
        if (p)
            check_px(id, px);
        vec++;
        assert (b === p) else begin
            miss++;
            $error("FAIL busy%0d got=%b expected=%b", id, b, p);
        end
        if (fd) begin
            fdc[id]++;
            vec++;
            assert (lp[id] === 1'b1 && lx[id] == width_of(id) - 1) else begin
                miss++;
                $error("FAIL fd%0d_pos got=plot%b_x%0d expected=plot1_x%0d", id, lp[id], lx[id],
                       width_of(id) - 1);
            end
        end
        lp[id] = p;
        lx[id] = int'(px[17:10]);
    endtask

    always @(negedge clk) begin
        mon(0, p1, b1, {x1, y1, c1}, f1);
        mon(1, p2, b2, {x2, y2, c2}, f2);
        mon(2, p3, b3, {x3, y3, c3}, f3);
    end

    task automatic wait_col(int id);
        int n;
        n = 0;
        while (!busy_of(id) && n < 3000) begin @(negedge clk); n++; end
        while (busy_of(id) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000)
            stop_now("wait_col");
        vec++;
        assert (sb[id].size() == 0) else begin
            miss++;
            $error("FAIL col%0d_left got=%0d expected=0", id, sb[id].size());
        end
    endtask

    task automatic feed(int id, logic [23:0] s);
        if (id == 0) begin
            repeat (4) begin @(posedge clk); #1 e1 = 1'b1; v1 = 1'b1; s1 = s; end
            @(posedge clk); #1 v1 = 1'b0;
        end else begin
            @(posedge clk); #1 v3 = 1'b1; s3 = s;
            @(posedge clk); #1 v3 = 1'b0;
        end
    endtask

    task automatic run_col(int id, logic [23:0] s, int ny);
        push_col(id, cx[id], 1, ny, 0, py[id], 0, colour_of(id), 3'b000);
        feed(id, s);
        wait_col(id);
        py[id] = ny;
        cx[id] = (cx[id] + 1) % width_of(id);
    endtask

    logic [47:0] pat [4];
    int ya [4];
    int yb [4];

    initial begin
        int n, j, pa, pb;
        r1 = 1; r2 = 1; r3 = 1;
        e1 = 1; e2 = 1; e3 = 1;
        cn1 = 1; cn2 = 0; cn3 = 0;
        a1 = 0; a2 = 0; a3 = 0;
        v1 = 0; v2 = 0; v3 = 0;
        s1 = '0; s2 = '0; s3 = '0;
        pat[0] = {24'hF00000, 24'h100000}; ya[0] = 52;  yb[0] = 68;
        pat[1] = {24'h100000, 24'hF00000}; ya[1] = 68;  yb[1] = 52;
        pat[2] = {24'h7FFFFF, 24'h800000}; ya[2] = 119; yb[2] = 0;
        pat[3] = {24'hFFFFFF, 24'h01FFFF}; ya[3] = 60;  yb[3] = 61;

        repeat (3) @(posedge clk);
        @(negedge clk);
        vec++; assert ({p1, x1, y1, c1, b1, f1, o1} === 21'd0) else begin
            miss++; $error("FAIL rst1 got=%b expected=0", {p1, x1, y1, c1, b1, f1, o1}); end
        vec++; assert ({p2, x2, y2, c2, b2, f2, o2} === 21'd0) else begin
            miss++; $error("FAIL rst2 got=%b expected=0", {p2, x2, y2, c2, b2, f2, o2}); end
        vec++; assert ({p3, x3, y3, c3, b3, f3, o3} === 21'd0) else begin
            miss++; $error("FAIL rst3 got=%b expected=0", {p3, x3, y3, c3, b3, f3, o3}); end
        @(posedge clk); #1 r1 = 0; r2 = 0; r3 = 0;

        // dut1: valid samples with enable low must not advance decimation
        repeat (3) begin @(posedge clk); #1 e1 = 1'b0; v1 = 1'b1; s1 = 24'h7FFFFF; end
        push_col(0, 0, 1, 52, 0, 52, 0, 3'b010, 3'b000);
        repeat (4) begin @(posedge clk); #1 e1 = 1'b1; v1 = 1'b1; s1 = 24'h100000; end
        @(posedge clk); #1 v1 = 1'b0;
        @(negedge clk);
        vec++; assert ({p1, b1} === 2'b00) else begin
            miss++; $error("FAIL lat_t1 got=%b expected=00", {p1, b1}); end
        @(negedge clk);
        vec++; assert ({p1, x1, y1, c1} === {1'b1, 8'd0, 7'd0, 3'd0}) else begin
            miss++; $error("FAIL lat_t2 got=%b expected=1 x0 y0 c0", {p1, x1, y1, c1}); end
        wait_col(0);
        py[0] = 52; cx[0] = 1;
        run_col(0, 24'hF00000, 68);
        run_col(0, 24'h7FFFFF, 0);
        run_col(0, 24'h800000, 119);
        run_col(0, 24'hFFFFFF, 61);
        run_col(0, 24'h000000, 60);
        for (int k = 6; k < 160; k++) begin
            run_col(0, 24'h000000, 60);
            if (k == 158) begin
                vec++; assert (fdc[0] == 0) else begin
                    miss++; $error("FAIL fd1_early got=%0d expected=0", fdc[0]); end
            end
        end
        repeat (2) @(negedge clk);
        vec++; assert (fdc[0] == 1) else begin
            miss++; $error("FAIL fd1_count got=%0d expected=1", fdc[0]); end
        run_col(0, 24'h100000, 52);
        vec++; assert (o1 === 1'b0) else begin
            miss++; $error("FAIL ovr1 got=%b expected=0", o1); end

        // dut1: reset while erasing row 50 of column 1
        push_col(0, 1, 1, 60, 0, 52, 0, 3'b010, 3'b000);
        feed(0, 24'h000000);
        n = 0;
        do begin @(negedge clk); n++; end while (!(p1 && y1 == 7'd50) && n < 500);
        if (n >= 500)
            stop_now("row50");
        #1 r1 = 1'b1;
        sb[0].delete();
        @(negedge clk);
        vec++; assert ({p1, x1, y1, c1, b1, f1, o1} === 21'd0) else begin
            miss++; $error("FAIL rst_mid got=%b expected=0", {p1, x1, y1, c1, b1, f1, o1}); end
        @(posedge clk); #1 r1 = 1'b0;
        repeat (5) @(posedge clk);
        cx[0] = 0;
        run_col(0, 24'h100000, 52);

        // dut2: valid every cycle, single-shot, samples changed mid-column
        s2 = pat[0];
        push_col(1, 0, 2, ya[0], yb[0], 0, 0, 3'b010, 3'b100);
        pa = ya[0]; pb = yb[0];
        @(negedge clk); v2 = 1'b1;
        for (int k = 0; k < 160; k++) begin
            n = 0;
            while (!(b2 && x2 == 8'(k)) && n < 1000) begin @(negedge clk); n++; end
            if (n >= 1000)
                stop_now("col2");
            if (k == 1) begin
                vec++; assert (o2 === 1'b1) else begin
                    miss++; $error("FAIL ovr2 got=%b expected=1", o2); end
            end
            if (k < 159) begin
                j = (k + 1) % 4;
                s2 = pat[j];
                push_col(1, k + 1, 2, ya[j], yb[j], pa, pb, 3'b010, 3'b100);
                pa = ya[j]; pb = yb[j];
            end
        end
        n = 0;
        while (b2 && n < 1000) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        vec++; assert (sb[1].size() == 0) else begin
            miss++; $error("FAIL col2_left got=%0d expected=0", sb[1].size()); end
        vec++; assert (fdc[1] == 1) else begin
            miss++; $error("FAIL fd2_count got=%0d expected=1", fdc[1]); end
        repeat (30) @(negedge clk);
        push_col(1, 0, 2, ya[3], yb[3], 0, 0, 3'b010, 3'b100);
        a2 = 1'b1;
        @(negedge clk); a2 = 1'b0;
        n = 0;
        while (!(b2 && x2 == 8'd0) && n < 1000) begin @(negedge clk); n++; end
        v2 = 1'b0;
        wait_col(1);

        // dut3: four-column single-shot screen
        cx[2] = 0; py[2] = 60;
        run_col(2, 24'h100000, 52);
        run_col(2, 24'h000000, 60);
        @(posedge clk); #1 a3 = 1'b1;
        @(posedge clk); #1 a3 = 1'b0;
        run_col(2, 24'h000000, 60);
        run_col(2, 24'hF00000, 68);
        repeat (2) @(negedge clk);
        vec++; assert (fdc[2] == 1) else begin
            miss++; $error("FAIL fd3_count got=%0d expected=1", fdc[2]); end
        repeat (5) feed(2, 24'h7FFFFF);
        repeat (3) @(negedge clk);
        vec++; assert (o3 === 1'b0) else begin
            miss++; $error("FAIL ovr3_done got=%b expected=0", o3); end
        @(posedge clk); #1 a3 = 1'b1;
        @(posedge clk); #1 a3 = 1'b0;
        run_col(2, 24'h7FFFFF, 0);
        vec++; assert (o3 === 1'b0) else begin
            miss++; $error("FAIL ovr3_end got=%b expected=0", o3); end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
